// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Matrix keypad scanner. Drives one active-low row at a time,
//               samples synchronised active-low columns, classifies each full
//               frame as none / one key / multiple keys, debounces the frame
//               results and emits press/release/repeat events.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int CODE_W      = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int DEBOUNCE    = 3,
    parameter int REPEAT_EN   = 0,
    parameter int REPEAT_DLY  = 20,
    parameter int REPEAT_RATE = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COLS-1:0]   column,
    output logic [ROWS-1:0]   row,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_down,
    output logic              multi_key
);

    localparam int c_DWELL_W = $clog2(SCAN_DIV);
    localparam int c_ROW_W   = $clog2(ROWS);
    localparam int c_COL_W   = $clog2(COLS);
    localparam int c_MATCH_W = $clog2(DEBOUNCE + 1);
    localparam int c_RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    // Frame classification; the encoding equals the saturated key count.
    localparam logic [1:0] c_KIND_NONE  = 2'd0;
    localparam logic [1:0] c_KIND_ONE   = 2'd1;
    localparam logic [1:0] c_KIND_MULTI = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    // Synchroniser and scan timing
    logic [COLS-1:0]      r_col_meta;
    logic [COLS-1:0]      r_col_sync;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [c_ROW_W-1:0]   r_row_idx;
    logic [ROWS-1:0]      r_row;

    // Frame accumulator and the registered frame result
    logic [1:0]           r_acc_cnt;
    logic [CODE_W-1:0]    r_acc_idx;
    logic                 r_frame_end;
    logic [1:0]           r_frame_kind;
    logic [CODE_W-1:0]    r_frame_idx;

    // Debounce state
    logic [1:0]           r_prev_kind;
    logic [CODE_W-1:0]    r_prev_idx;
    logic [1:0]           r_stable_kind;
    logic [CODE_W-1:0]    r_stable_idx;
    logic [c_MATCH_W-1:0] r_match;

    // Event FSM and outputs
    state_t               r_state;
    logic [CODE_W-1:0]    r_key_code;
    logic                 r_key_valid;
    logic                 r_key_release;
    logic                 r_key_down;
    logic                 r_multi_key;
    logic [c_RPT_W-1:0]   r_rpt_cnt;

    logic                 w_sample;
    logic                 w_last_row;
    logic [c_ROW_W-1:0]   w_row_idx_nxt;
    logic [1:0]           w_row_cnt;
    logic [c_COL_W-1:0]   w_first_col;
    logic                 w_row_hit;
    logic [CODE_W-1:0]    w_first_idx;
    logic [2:0]           w_acc_sum;
    logic [1:0]           w_acc_cnt_nxt;
    logic [CODE_W-1:0]    w_acc_idx_nxt;
    logic [CODE_W-1:0]    w_frame_idx;

    logic                 w_same_prev;
    logic                 w_diff_stable;
    logic [c_MATCH_W-1:0] w_match_nxt;
    logic                 w_commit;

    state_t               w_state_nxt;
    logic [CODE_W-1:0]    w_code_nxt;
    logic                 w_down_nxt;
    logic                 w_multi_nxt;
    logic                 w_valid_nxt;
    logic                 w_release_nxt;
    logic [c_RPT_W-1:0]   w_rpt_nxt;

    assign w_sample      = (r_dwell == c_DWELL_W'(SCAN_DIV - 1));
    assign w_last_row    = (r_row_idx == c_ROW_W'(ROWS - 1));
    assign w_row_idx_nxt = w_last_row ? '0 : r_row_idx + c_ROW_W'(1);
    assign w_first_idx   = CODE_W'(32'(r_row_idx) * 32'(COLS) + 32'(w_first_col));

    // Two-flop synchroniser on the raw column lines (idle level is high).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            r_col_meta <= column;
            r_col_sync <= r_col_meta;
        end
    end

    // Count low columns in the current row (saturating at 2) and find the first.
    always_comb begin
        w_row_cnt   = 2'd0;
        w_first_col = '0;
        w_row_hit   = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (!r_col_sync[c]) begin
                if (!w_row_hit) begin
                    w_first_col = c_COL_W'(c);
                    w_row_hit   = 1'b1;
                end
                if (w_row_cnt != 2'd2) begin
                    w_row_cnt = w_row_cnt + 2'd1;
                end
            end
        end
    end

    // Merge this row's sample into the running frame accumulator.
    always_comb begin
        w_acc_sum     = {1'b0, r_acc_cnt} + {1'b0, w_row_cnt};
        w_acc_cnt_nxt = (w_acc_sum >= 3'd2) ? 2'd2 : w_acc_sum[1:0];
        w_acc_idx_nxt = (r_acc_cnt == 2'd0 && w_row_hit) ? w_first_idx : r_acc_idx;
        w_frame_idx   = (w_acc_cnt_nxt == c_KIND_ONE) ? w_acc_idx_nxt : '0;
    end

    // Row dwell timing, row drive and per-frame accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell      <= '0;
            r_row_idx    <= '0;
            r_row        <= ~ROWS'(1);
            r_acc_cnt    <= 2'd0;
            r_acc_idx    <= '0;
            r_frame_end  <= 1'b0;
            r_frame_kind <= c_KIND_NONE;
            r_frame_idx  <= '0;
        end else begin
            r_frame_end <= w_sample && w_last_row;
            if (w_sample) begin
                r_dwell   <= '0;
                r_row_idx <= w_row_idx_nxt;
                r_row     <= ~(ROWS'(1) << w_row_idx_nxt);
                if (w_last_row) begin
                    r_frame_kind <= w_acc_cnt_nxt;
                    r_frame_idx  <= w_frame_idx;
                    r_acc_cnt    <= 2'd0;
                    r_acc_idx    <= '0;
                end else begin
                    r_acc_cnt <= w_acc_cnt_nxt;
                    r_acc_idx <= w_acc_idx_nxt;
                end
            end else begin
                r_dwell <= r_dwell + c_DWELL_W'(1);
            end
        end
    end

    // Debounce: count identical consecutive frame results, commit on a change.
    always_comb begin
        w_same_prev   = (r_frame_kind == r_prev_kind) && (r_frame_idx == r_prev_idx);
        w_diff_stable = (r_frame_kind != r_stable_kind) || (r_frame_idx != r_stable_idx);
        if (!w_same_prev) begin
            w_match_nxt = c_MATCH_W'(1);
        end else if (r_match == c_MATCH_W'(DEBOUNCE)) begin
            w_match_nxt = r_match;
        end else begin
            w_match_nxt = r_match + c_MATCH_W'(1);
        end
        w_commit = r_frame_end && (w_match_nxt == c_MATCH_W'(DEBOUNCE)) && w_diff_stable;
    end

    // Debounce registers update once per frame, one cycle after the last row sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_kind   <= c_KIND_NONE;
            r_prev_idx    <= '0;
            r_stable_kind <= c_KIND_NONE;
            r_stable_idx  <= '0;
            r_match       <= c_MATCH_W'(DEBOUNCE);
        end else if (r_frame_end) begin
            r_match <= w_match_nxt;
            if (!w_same_prev) begin
                r_prev_kind <= r_frame_kind;
                r_prev_idx  <= r_frame_idx;
            end
            if (w_commit) begin
                r_stable_kind <= r_frame_kind;
                r_stable_idx  <= r_frame_idx;
            end
        end
    end

    // Event FSM: reacts to commits, otherwise runs the auto-repeat countdown.
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_key_code;
        w_down_nxt    = r_key_down;
        w_multi_nxt   = r_multi_key;
        w_valid_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_rpt_nxt     = r_rpt_cnt;
        if (w_commit) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_frame_kind == c_KIND_ONE) begin
                        w_state_nxt = ST_HELD;
                        w_code_nxt  = r_frame_idx;
                        w_down_nxt  = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_rpt_nxt   = c_RPT_W'(REPEAT_DLY);
                    end else if (r_frame_kind == c_KIND_MULTI) begin
                        w_state_nxt = ST_BLOCKED;
                        w_multi_nxt = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (r_frame_kind == c_KIND_NONE) begin
                        w_state_nxt   = ST_IDLE;
                        w_down_nxt    = 1'b0;
                        w_release_nxt = 1'b1;
                    end else if (r_frame_kind == c_KIND_ONE) begin
                        w_code_nxt  = r_frame_idx;
                        w_valid_nxt = 1'b1;
                        w_rpt_nxt   = c_RPT_W'(REPEAT_DLY);
                    end else begin
                        w_state_nxt   = ST_BLOCKED;
                        w_down_nxt    = 1'b0;
                        w_release_nxt = 1'b1;
                        w_multi_nxt   = 1'b1;
                    end
                end
                ST_BLOCKED: begin
                    // A single key here is ignored until everything is released.
                    if (r_frame_kind == c_KIND_NONE) begin
                        w_state_nxt = ST_IDLE;
                        w_multi_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else if (REPEAT_EN != 0 && r_frame_end && r_state == ST_HELD) begin
            if (r_rpt_cnt <= c_RPT_W'(1)) begin
                w_valid_nxt = 1'b1;
                w_rpt_nxt   = c_RPT_W'(REPEAT_RATE);
            end else begin
                w_rpt_nxt = r_rpt_cnt - c_RPT_W'(1);
            end
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_down    <= 1'b0;
            r_multi_key   <= 1'b0;
            r_rpt_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_key_code    <= w_code_nxt;
            r_key_valid   <= w_valid_nxt;
            r_key_release <= w_release_nxt;
            r_key_down    <= w_down_nxt;
            r_multi_key   <= w_multi_nxt;
            r_rpt_cnt     <= w_rpt_nxt;
        end
    end

    assign row         = r_row;
    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_release = r_key_release;
    assign key_down    = r_key_down;
    assign multi_key   = r_multi_key;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. Two instances share
//               clock and reset: A without auto-repeat, B with auto-repeat.
//               Expected events are queued with their due cycle when keys are
//               driven and matched when the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int c_FRAME = 32;   // ROWS * SCAN_DIV

    logic        clk;
    logic        reset;
    logic [15:0] keys_a;
    logic [15:0] keys_b;
    logic [3:0]  col_a, col_b;
    logic [3:0]  row_a, row_b;
    logic [3:0]  code_a, code_b;
    logic        valid_a, valid_b, release_a, release_b;
    logic        down_a, down_b, multi_a, multi_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit rel;
        int code;
        int at;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    ev_t e_a;
    ev_t e_b;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(8), .DEBOUNCE(3),
        .REPEAT_EN(0), .REPEAT_DLY(3), .REPEAT_RATE(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .column(col_a), .row(row_a),
        .key_code(code_a), .key_valid(valid_a), .key_release(release_a),
        .key_down(down_a), .multi_key(multi_a)
    );

    keypad_scanner #(
        .ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(8), .DEBOUNCE(3),
        .REPEAT_EN(1), .REPEAT_DLY(3), .REPEAT_RATE(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .column(col_b), .row(row_b),
        .key_code(code_b), .key_valid(valid_b), .key_release(release_b),
        .key_down(down_b), .multi_key(multi_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since the last reset edge: the bench's own timing reference.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Key matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_a = 4'hF;
        col_b = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_a[r*4+c] && row_a[r] == 1'b0) col_a[c] = 1'b0;
                if (keys_b[r*4+c] && row_b[r] == 1'b0) col_b[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 4000; i++) begin
            if (cyc == t) return;
            step();
        end
        check("wait_timeout", cyc, t);
    endtask

    task automatic goto_frame_start(output int c);
        for (int i = 0; i < 2 * c_FRAME; i++) begin
            if (cyc % c_FRAME == 1) break;
            step();
        end
        if (cyc % c_FRAME != 1) check("frame_sync_timeout", cyc % c_FRAME, 1);
        c = cyc;
    endtask

    task automatic push_a(input bit rel, input int code, input int at);
        q_a.push_back('{rel: rel, code: code, at: at});
    endtask

    task automatic push_b(input bit rel, input int code, input int at);
        q_b.push_back('{rel: rel, code: code, at: at});
    endtask

    // Scoreboard for instance A: every pulse must match the next expected event.
    always @(negedge clk) begin
        if (reset === 1'b0 && (valid_a === 1'b1 || release_a === 1'b1)) begin
            check("a_valid_and_release", 32'(valid_a & release_a), 0);
            if (q_a.size() == 0) begin
                check("a_unexpected_event", {30'd0, release_a, valid_a}, 0);
            end else begin
                e_a = q_a.pop_front();
                check("a_kind", 32'(release_a), 32'(e_a.rel));
                check("a_code", 32'(code_a), e_a.code);
                check("a_cycle", cyc, e_a.at);
                check("a_key_down", 32'(down_a), 32'(!e_a.rel));
            end
        end
    end

    // Scoreboard for instance B (auto-repeat).
    always @(negedge clk) begin
        if (reset === 1'b0 && (valid_b === 1'b1 || release_b === 1'b1)) begin
            check("b_valid_and_release", 32'(valid_b & release_b), 0);
            if (q_b.size() == 0) begin
                check("b_unexpected_event", {30'd0, release_b, valid_b}, 0);
            end else begin
                e_b = q_b.pop_front();
                check("b_kind", 32'(release_b), 32'(e_b.rel));
                check("b_code", 32'(code_b), e_b.code);
                check("b_cycle", cyc, e_b.at);
                check("b_key_down", 32'(down_b), 32'(!e_b.rel));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1;
        logic [3:0] exp_row;

        reset  = 1'b1;
        keys_a = '0;
        keys_b = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_row", row_a, 4'b1110);
        check("rst_code", code_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_release", release_a, 0);
        check("rst_down", down_a, 0);
        check("rst_multi", multi_a, 0);
        check("rst_b_code", code_b, 0);

        // Row sequence: 1110, 1101, 1011, 0111, each held 8 clocks
        for (int i = 0; i < 40; i++) begin
            exp_row = ~(4'b0001 << ((cyc / 8) % 4));
            check("row_seq", row_a, exp_row);
            step();
        end
        check("idle_down", down_a, 0);

        // Key 9 held 5 frames then released
        goto_frame_start(c0);
        keys_a = 16'(1) << 9;
        push_a(1'b0, 9, c0 + 3 * c_FRAME);
        wait_cyc(c0 + 3 * c_FRAME - 1);
        check("k9_down_before_commit", down_a, 0);
        wait_cyc(c0 + 5 * c_FRAME);
        check("k9_down_held", down_a, 1);
        keys_a = '0;
        push_a(1'b1, 9, c0 + 8 * c_FRAME);
        wait_cyc(c0 + 8 * c_FRAME + 2);
        check("k9_down_after_release", down_a, 0);
        check("k9_code_holds", code_a, 9);

        // Bounce: key 5 for only 2 frames
        goto_frame_start(c0);
        keys_a = 16'(1) << 5;
        wait_cyc(c0 + 2 * c_FRAME);
        keys_a = '0;
        wait_cyc(c0 + 6 * c_FRAME);
        check("bounce_down", down_a, 0);
        check("bounce_code", code_a, 9);

        // Multi-key: keys 0 and 6, then key 6 released alone, then all released
        goto_frame_start(c0);
        keys_a = (16'(1) << 0) | (16'(1) << 6);
        wait_cyc(c0 + 3 * c_FRAME - 1);
        check("multi_before_commit", multi_a, 0);
        step();
        check("multi_commit", multi_a, 1);
        check("multi_no_down", down_a, 0);
        wait_cyc(c0 + 4 * c_FRAME);
        keys_a = 16'(1) << 0;
        wait_cyc(c0 + 8 * c_FRAME);
        check("multi_partial_release", multi_a, 1);
        keys_a = '0;
        wait_cyc(c0 + 11 * c_FRAME - 1);
        check("multi_before_clear", multi_a, 1);
        step();
        check("multi_cleared", multi_a, 0);

        // Auto-repeat on B: key 3 held 10 frames
        goto_frame_start(c0);
        keys_b = 16'(1) << 3;
        push_b(1'b0, 3, c0 + 3 * c_FRAME);
        push_b(1'b0, 3, c0 + 6 * c_FRAME);
        push_b(1'b0, 3, c0 + 8 * c_FRAME);
        push_b(1'b0, 3, c0 + 10 * c_FRAME);
        push_b(1'b0, 3, c0 + 12 * c_FRAME);
        wait_cyc(c0 + 10 * c_FRAME);
        keys_b = '0;
        push_b(1'b1, 3, c0 + 13 * c_FRAME);
        wait_cyc(c0 + 13 * c_FRAME + 2);
        check("rep_queue_empty", q_b.size(), 0);
        check("rep_down_after", down_b, 0);

        // Roll-over from key 2 to key 14, then reset while 14 is held
        goto_frame_start(c0);
        keys_a = 16'(1) << 2;
        push_a(1'b0, 2, c0 + 3 * c_FRAME);
        wait_cyc(c0 + 4 * c_FRAME);
        keys_a = 16'(1) << 14;
        push_a(1'b0, 14, c0 + 7 * c_FRAME);
        wait_cyc(c0 + 7 * c_FRAME + 16);
        check("roll_code", code_a, 14);
        check("roll_down", down_a, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_row", row_a, 4'b1110);
        check("mid_rst_code", code_a, 0);
        check("mid_rst_down", down_a, 0);
        check("mid_rst_valid", valid_a, 0);
        check("mid_rst_release", release_a, 0);
        check("mid_rst_multi", multi_a, 0);
        push_a(1'b0, 14, 3 * c_FRAME + 1);
        wait_cyc(3 * c_FRAME + 2);
        check("recommit_code", code_a, 14);
        check("recommit_down", down_a, 1);
        goto_frame_start(c1);
        keys_a = '0;
        push_a(1'b1, 14, c1 + 3 * c_FRAME);
        wait_cyc(c1 + 3 * c_FRAME + 4);

        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
